uart_time_cmd_parser: RTL and testbench

//   Upstream control stage of the UART-settable clock. Parses ASCII time-set commands

---
 rtl/uart_time_cmd_parser.sv | 143 ++++++++++++++
 tb/tb_uart_time_cmd_parser.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_time_cmd_parser.sv
// rtl/uart_time_cmd_parser.sv - ASCII "Tmmss<CR>" / "R" command parser driving the clock digit reconfig inputs
// Every command gets exactly one status byte: 'K' on success, 'E' on a rejected or timed-out command.
module uart_time_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TO_W           = 26
) (
  input  logic       clk,
  input  logic       resett,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] sec_reconfig_l,
  output logic [3:0] sec_reconfig_m,
  output logic [3:0] min_reconfig_l,
  output logic [3:0] min_reconfig_m,
  output logic       reconfig_en,
  output logic       clear,
  output logic       cmd_error,
  output logic       busy
);

  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_TL   = 8'h74;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_RL   = 8'h72;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MT, MU, ST, SU, WCR, APPLY, RESP} state_t;

  state_t          state;
  logic [3:0]      sh_min_m, sh_min_l, sh_sec_m, sh_sec_l;
  logic [TO_W-1:0] to_cnt;

  logic is_t, is_r, in_cmd, byte_ok, fault;

  // fault covers both a bad byte and the inter-byte timeout; a received byte wins over expiry
  always_comb begin
    is_t    = (rx_data == CH_T) || (rx_data == CH_TL);
    is_r    = (rx_data == CH_R) || (rx_data == CH_RL);
    in_cmd  = (state == MT) || (state == MU) || (state == ST) ||
              (state == SU) || (state == WCR);
    byte_ok = 1'b0;
    case (state)
      MT, ST:  byte_ok = (rx_data >= 8'h30) && (rx_data <= 8'h35);
      MU, SU:  byte_ok = (rx_data >= 8'h30) && (rx_data <= 8'h39);
      WCR:     byte_ok = (rx_data == CH_CR);
      default: byte_ok = 1'b0;
    endcase
    fault = in_cmd && (rx_valid ? (!is_t && !byte_ok) : (to_cnt == TO_LAST));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge resett) begin
    if (!resett) begin
      state          <= IDLE;
      sh_min_m       <= 4'd0;
      sh_min_l       <= 4'd0;
      sh_sec_m       <= 4'd0;
      sh_sec_l       <= 4'd0;
      to_cnt         <= '0;
      tx_data        <= 8'h00;
      tx_valid       <= 1'b0;
      sec_reconfig_l <= 4'd0;
      sec_reconfig_m <= 4'd0;
      min_reconfig_l <= 4'd0;
      min_reconfig_m <= 4'd0;
      reconfig_en    <= 1'b0;
      clear          <= 1'b0;
      cmd_error      <= 1'b0;
    end else begin
      reconfig_en <= 1'b0;
      clear       <= 1'b0;
      cmd_error   <= 1'b0;
      if (fault) begin
        cmd_error <= 1'b1;
        tx_data   <= RSP_ERR;
        tx_valid  <= 1'b1;
        state     <= RESP;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid) begin
              if (is_t) begin
                to_cnt <= '0;
                state  <= MT;
              end else if (is_r) begin
                clear    <= 1'b1;
                tx_data  <= RSP_OK;
                tx_valid <= 1'b1;
                state    <= RESP;
              end
            end
          end
          MT, MU, ST, SU, WCR: begin
            if (rx_valid) begin
              to_cnt <= '0;
              if (is_t) begin
                state <= MT;
              end else begin
                case (state)
                  MT: begin sh_min_m <= rx_data[3:0]; state <= MU;  end
                  MU: begin sh_min_l <= rx_data[3:0]; state <= ST;  end
                  ST: begin sh_sec_m <= rx_data[3:0]; state <= SU;  end
                  SU: begin sh_sec_l <= rx_data[3:0]; state <= WCR; end
                  default: begin
                    // digits are driven in the same edge as the strobe so they are valid with reconfig_en
                    min_reconfig_m <= sh_min_m;
                    min_reconfig_l <= sh_min_l;
                    sec_reconfig_m <= sh_sec_m;
                    sec_reconfig_l <= sh_sec_l;
                    reconfig_en    <= 1'b1;
                    state          <= APPLY;
                  end
                endcase
              end
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          APPLY: begin
            tx_data  <= RSP_OK;
            tx_valid <= 1'b1;
            state    <= RESP;
          end
          RESP: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_time_cmd_parser.sv
// tb/tb_uart_time_cmd_parser.sv - scoreboard bench for uart_time_cmd_parser
// The reference model interprets the byte stream as text: a pending "T" command plus the digits collected so far.
module tb_uart_time_cmd_parser;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       resett = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [3:0] sec_reconfig_l, sec_reconfig_m, min_reconfig_l, min_reconfig_m;
  logic       reconfig_en, clear, cmd_error, busy;

  uart_time_cmd_parser #(.TIMEOUT_CYCLES(TMO), .TO_W(6)) dut (
    .clk(clk), .resett(resett), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .sec_reconfig_l(sec_reconfig_l), .sec_reconfig_m(sec_reconfig_m),
    .min_reconfig_l(min_reconfig_l), .min_reconfig_m(min_reconfig_m),
    .reconfig_en(reconfig_en), .clear(clear), .cmd_error(cmd_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wire [15:0] dut_dig = {min_reconfig_m, min_reconfig_l, sec_reconfig_m, sec_reconfig_l};

  typedef struct {
    int          kind;   // 0 reconfig, 1 clear, 2 error
    logic [15:0] dig;
    int          at;
  } strobe_t;

  strobe_t    sq[$];
  logic [7:0] tq[$];
  int         total = 0;
  int         bad = 0;
  logic [15:0] exp_out = 16'h0000;
  bit         active = 0;
  int         len = 0;
  logic [3:0] d [4];
  bit         hold_ready = 0;
  int         last_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_err(input int at);
    sq.push_back('{kind: 2, dig: 16'h0, at: at});
    tq.push_back(8'h45);
    active = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input int c, output bit done);
    logic [7:0] lim;
    done = 0;
    if (!active) begin
      if (b == "T" || b == "t") begin
        active = 1;
        len = 0;
      end else if (b == "R" || b == "r") begin
        sq.push_back('{kind: 1, dig: 16'h0, at: c + 1});
        tq.push_back(8'h4B);
        done = 1;
      end
    end else if (b == "T" || b == "t") begin
      len = 0;
    end else if (len < 4) begin
      lim = (len == 0 || len == 2) ? 8'h35 : 8'h39;
      if (b >= 8'h30 && b <= lim) begin
        d[len] = b[3:0];
        len++;
      end else begin
        push_err(c + 1);
        done = 1;
      end
    end else if (b == 8'h0D) begin
      exp_out = {d[0], d[1], d[2], d[3]};
      sq.push_back('{kind: 0, dig: exp_out, at: c + 1});
      tq.push_back(8'h4B);
      active = 0;
      done = 1;
    end else begin
      push_err(c + 1);
      done = 1;
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT strobes or hands off a byte
  initial begin
    logic pe, pc, pr, ptv, ptr;
    logic [7:0] ptd;
    strobe_t s;
    int kind;
    pe = 0; pc = 0; pr = 0; ptv = 0; ptr = 0; ptd = 0;
    forever begin
      @(negedge clk);
      if (!resett) begin
        pe = 0; pc = 0; pr = 0; ptv = 0; ptr = 0;
        continue;
      end
      check("strobe_excl", 32'(reconfig_en) + 32'(clear) + 32'(cmd_error) > 1, 0);
      check("strobe_width", {reconfig_en & pe, clear & pc, cmd_error & pr}, 0);
      if (reconfig_en || clear || cmd_error) begin
        kind = reconfig_en ? 0 : (clear ? 1 : 2);
        if (sq.size() == 0) begin
          check("unexpected_strobe_kind", kind, 32'hFF);
        end else begin
          s = sq.pop_front();
          check("strobe_kind", kind, s.kind);
          check("strobe_cycle", cyc, s.at);
          if (kind == 0) check("reconf_digits", dut_dig, s.dig);
        end
      end
      if (pe) check("tx_latency", tx_valid, 1);
      if (ptv && !ptr) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, ptd);
      end
      if (tx_valid && tx_ready) begin
        if (tq.size() == 0) check("unexpected_tx", tx_data, 32'hFFFF);
        else check("tx_byte", tx_data, tq.pop_front());
      end
      pe = reconfig_en; pc = clear; pr = cmd_error;
      ptv = tx_valid; ptr = tx_ready; ptd = tx_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit done);
    rx_data = b;
    rx_valid = 1'b1;
    last_cyc = cyc;
    model_step(b, cyc, done);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data = $urandom_range(0, 255);
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int maxgap);
    bit done;
    foreach (q[i]) begin
      send_byte(q[i], done);
      if (done) wait_idle(300);
      else repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_str(input string s, input int maxgap);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    send_seq(q, maxgap);
  endtask

  initial begin
    bit done;
    logic [7:0] q[$];
    logic [7:0] dg;
    #2 resett = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_digits", dut_dig, 0);
    check("rst_strobes", {reconfig_en, clear, cmd_error}, 0);
    check("rst_busy", busy, 0);
    resett = 1'b1;
    @(posedge clk);
    #1;

    send_str("T1234\015", 0);
    check("t1_digits", dut_dig, 16'h1234);

    send_str("T6", 0);
    check("t2_digits_kept", dut_dig, 16'h1234);
    check("t2_busy", busy, 0);

    send_str("T05T5959\015", 1);
    check("t3_digits", dut_dig, 16'h5959);

    send_str("T1", 0);
    push_err(last_cyc + TMO + 1);
    wait_idle(TMO + 300);
    check("t4_digits_kept", dut_dig, 16'h5959);

    hold_ready = 1;
    send_byte("R", done);
    repeat (20) begin @(posedge clk); #1; end
    check("t5_tx_valid", tx_valid, 1);
    check("t5_tx_data", tx_data, 8'h4B);
    hold_ready = 0;
    wait_idle(300);

    send_str("T123", 0);
    resett = 1'b0;
    #1;
    check("t6_digits", dut_dig, 0);
    check("t6_tx_valid", tx_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_strobes", {reconfig_en, clear, cmd_error}, 0);
    active = 0;
    exp_out = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    resett = 1'b1;
    @(posedge clk);
    #1;
    send_str("T4321\015", 2);
    check("t6_after", dut_dig, 16'h4321);

    for (int it = 0; it < 80; it++) begin
      q = {};
      if (it % 2 == 0) begin
        q.push_back(($urandom_range(0, 1) != 0) ? "T" : "t");
        for (int k = 0; k < 4; k++) begin
          dg = 8'h30 + 8'($urandom_range(0, (k % 2 == 0) ? 5 : 9));
          if ($urandom_range(0, 15) == 0) dg = 8'h30 + 8'($urandom_range(0, 9));
          q.push_back(dg);
        end
        q.push_back(($urandom_range(0, 9) == 0) ? 8'h0A : 8'h0D);
      end else begin
        for (int k = 0; k < 8; k++) begin
          case ($urandom_range(0, 9))
            0:       q.push_back("T");
            1:       q.push_back(($urandom_range(0, 1) != 0) ? "R" : "r");
            2:       q.push_back(8'h0D);
            3:       q.push_back(8'($urandom_range(0, 255)));
            default: q.push_back(8'h30 + 8'($urandom_range(0, 9)));
          endcase
        end
      end
      send_seq(q, 3);
      check("rand_outputs", dut_dig, exp_out);
    end
    if (active) send_str("x", 0);

    wait_idle(300);
    repeat (5) @(posedge clk);
    check("sq_empty", sq.size(), 0);
    check("tq_empty", tq.size(), 0);
    check("final_outputs", dut_dig, exp_out);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
